// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and DDRAM address stepping for the HD44780 responder.
package lcd_pkg;

  localparam logic [7:0] CMD_CLR   = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [6:0] LINE1_END  = 7'h27;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE2_END  = 7'h67;
  localparam logic [7:0] BLANK      = 8'h20;

  typedef enum logic [1:0] {CLEARING, BUSY, IDLE} state_t;

  function automatic logic addr_mapped(input logic [6:0] a);
    return (a <= LINE1_END) || ((a >= LINE2_BASE) && (a <= LINE2_END));
  endfunction

  // Unmapped addresses snap to the next line start (up) or previous line end (down).
  function automatic logic [6:0] addr_inc(input logic [6:0] a);
    if (a < LINE1_END)       return a + 7'd1;
    else if (a < LINE2_BASE) return LINE2_BASE;
    else if (a < LINE2_END)  return a + 7'd1;
    else                     return '0;
  endfunction

  function automatic logic [6:0] addr_dec(input logic [6:0] a);
    if (a == 7'h00)           return LINE2_END;
    else if (a <= LINE1_END)  return a - 7'd1;
    else if (a <= LINE2_BASE) return LINE1_END;
    else if (a <= LINE2_END)  return a - 7'd1;
    else                      return LINE2_END;
  endfunction

  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
    return up ? addr_inc(a) : addr_dec(a);
  endfunction

endpackage

// File: rtl/hd44780_ddram.sv
// 80-byte display RAM addressed by the 7-bit HD44780 DDRAM address; unmapped reads give blank.
module hd44780_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] host_addr,
  output logic [7:0] host_data,
  input  logic [6:0] mon_addr,
  output logic [7:0] mon_data
);

  logic [7:0] mem [0:79];

  function automatic logic [6:0] lin(input logic [6:0] a);
    if (a <= LINE1_END) return a;
    if (addr_mapped(a)) return a - 7'd24;
    return '0;
  endfunction

  always_ff @(posedge clk) begin
    if (we && addr_mapped(waddr)) mem[lin(waddr)] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_data <= '0;
      mon_data  <= '0;
    end else begin
      host_data <= addr_mapped(host_addr) ? mem[lin(host_addr)] : BLANK;
      mon_data  <= addr_mapped(mon_addr)  ? mem[lin(mon_addr)]  : BLANK;
    end
  end

endmodule

// File: rtl/hd44780_responder.sv
// Device side of an 8-bit HD44780 bus: decodes host accesses on E edges, models busy time,
// and exposes DDRAM through a monitor port.
module hd44780_responder
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 925,
  parameter int unsigned CLEAR_CYCLES = 38000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lcd_d_in,
  output logic [7:0] lcd_d_out,
  output logic       lcd_d_oe,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [6:0] mon_addr,
  output logic [7:0] mon_data,
  output logic       busy,
  output logic       display_on,
  output logic       cmd_error
);

  localparam int unsigned CNT_MAX = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 80);

  logic       e_s1, e_s2, e_prev, rs_s1, rs_s2, rw_s1, rw_s2;
  logic [7:0] d_s1, d_s2;
  logic       e_rise, e_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_s1 <= 1'b0; e_s2 <= 1'b0; e_prev <= 1'b0;
      rs_s1 <= 1'b0; rs_s2 <= 1'b0;
      rw_s1 <= 1'b0; rw_s2 <= 1'b0;
      d_s1 <= '0; d_s2 <= '0;
    end else begin
      e_s1 <= lcd_e;    e_s2 <= e_s1;  e_prev <= e_s2;
      rs_s1 <= lcd_rs;  rs_s2 <= rs_s1;
      rw_s1 <= lcd_rw;  rw_s2 <= rw_s1;
      d_s1 <= lcd_d_in; d_s2 <= d_s1;
    end
  end

  assign e_rise   = e_s2 & ~e_prev;
  assign e_fall   = ~e_s2 & e_prev;
  assign lcd_d_oe = e_s2 & rw_s2;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0]    clr_addr, clr_n, addr, addr_n;
  logic          inc_mode, inc_n, disp_n, err_n;
  logic [7:0]    dout_n, host_data;
  logic          we;
  logic [6:0]    waddr;
  logic [7:0]    wdata;

  assign busy = (state != IDLE);

  hd44780_ddram u_ddram (
    .clk       (clk),
    .rst       (reset),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .host_addr (addr),
    .host_data (host_data),
    .mon_addr  (mon_addr),
    .mon_data  (mon_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEARING;
      cnt        <= '0;
      clr_addr   <= '0;
      addr       <= '0;
      inc_mode   <= 1'b1;
      display_on <= 1'b0;
      lcd_d_out  <= '0;
      cmd_error  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      clr_addr   <= clr_n;
      addr       <= addr_n;
      inc_mode   <= inc_n;
      display_on <= disp_n;
      lcd_d_out  <= dout_n;
      cmd_error  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clr_n   = clr_addr;
    addr_n  = addr;
    inc_n   = inc_mode;
    disp_n  = display_on;
    dout_n  = lcd_d_out;
    err_n   = 1'b0;
    we      = 1'b0;
    waddr   = addr;
    wdata   = d_s2;

    unique case (state)
      CLEARING: begin
        we    = 1'b1;
        waddr = clr_addr;
        wdata = BLANK;
        clr_n = addr_inc(clr_addr);
        if (clr_addr == LINE2_END) begin
          state_n = BUSY;
          cnt_n   = CLEAR_LOAD;
        end
      end
      BUSY: begin
        if (cnt <= CW'(1)) state_n = IDLE;
        else               cnt_n   = cnt - CW'(1);
      end
      default: ;
    endcase

    if (e_rise && rw_s2) dout_n = rs_s2 ? host_data : {busy, addr};

    // Busy-flag reads never touch state; every other E fall needs IDLE as sampled this cycle.
    if (e_fall && !(rw_s2 && !rs_s2)) begin
      if (state != IDLE) begin
        err_n = 1'b1;
      end else if (rw_s2) begin
        addr_n  = addr_step(addr, inc_mode);
        state_n = BUSY;
        cnt_n   = BUSY_LOAD;
      end else if (rs_s2) begin
        we      = 1'b1;
        waddr   = addr;
        wdata   = d_s2;
        addr_n  = addr_step(addr, inc_mode);
        state_n = BUSY;
        cnt_n   = BUSY_LOAD;
      end else if (d_s2 != '0) begin
        state_n = BUSY;
        cnt_n   = BUSY_LOAD;
        if ((d_s2 & CMD_DDRAM) != '0) begin
          addr_n = d_s2[6:0];
        end else if ((d_s2 & (CMD_CGRAM | CMD_FUNC)) != '0) begin
          addr_n = addr;
        end else if ((d_s2 & CMD_SHIFT) != '0) begin
          if (!d_s2[3]) addr_n = addr_step(addr, d_s2[2]);
        end else if ((d_s2 & CMD_DISP) != '0) begin
          disp_n = d_s2[2];
        end else if ((d_s2 & CMD_ENTRY) != '0) begin
          inc_n = d_s2[1];
        end else if ((d_s2 & CMD_HOME) != '0) begin
          addr_n = '0;
        end else begin
          addr_n  = '0;
          inc_n   = 1'b1;
          clr_n   = '0;
          state_n = CLEARING;
        end
      end
    end
  end

endmodule

// File: doc/hd44780_responder.md
Name: hd44780_responder

Overview:
- Synthesizable HD44780-compatible character LCD responder: the device end of the 8-bit LCD bus that the PicoBlaze LCD port logic drives (data, RS, RW, E).
- Decodes commands and data writes on E falling edge, answers busy-flag/address and DDRAM reads, and models busy time.
- Used as the LCD stand-in in simulation and on-chip loopback; exposes a monitor port so a bench or second display path can read DDRAM contents.

Parameters:
- BUSY_CYCLES, 925, busy duration after any accepted write or data read (37 us at 25 MHz).
- CLEAR_CYCLES, 38000, busy duration after Clear Display and after reset (1.52 ms at 25 MHz); must be at least 80.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- lcd_d_in  in  8  bus data driven by host
- lcd_d_out  out  8  read data toward host
- lcd_d_oe  out  1  high while responder drives bus
- lcd_rs  in  1  0 = instruction, 1 = data
- lcd_rw  in  1  0 = write, 1 = read
- lcd_e  in  1  enable strobe
- mon_addr  in  7  DDRAM monitor address
- mon_data  out  8  DDRAM[mon_addr], 1-cycle registered
- busy  out  1  busy flag
- display_on  out  1  D bit of Display On/Off
- cmd_error  out  1  one-cycle pulse: access rejected

Behaviour:
- Reset (asynchronous, active-high):
  - addr=0, inc_mode=1, display_on=0, lcd_d_out=0, lcd_d_oe=0, mon_data=0, cmd_error=0, busy=1.
  - On release, enter CLEARING. DDRAM has no reset; it is filled by CLEARING.
- Input synchronization: lcd_e, lcd_rs, lcd_rw and lcd_d_in each pass through a 2-flop synchronizer. E rise and fall are detected on the synchronized E.
- FSM states:
  - CLEARING: write 0x20 to one DDRAM location per cycle across both line ranges (80 cycles). Load the busy counter with CLEAR_CYCLES-80, then go to BUSY.
  - BUSY: decrement the counter; go to IDLE when it reaches 0.
  - IDLE: accept transactions. busy=0 only in IDLE.
- DDRAM addressing:
  - Valid addresses: line 1 = 0x00–0x27, line 2 = 0x40–0x67.
  - Increment wraps 0x27→0x40 and 0x67→0x00. Decrement wraps 0x00→0x67 and 0x40→0x27.
  - Set DDRAM Address with an unmapped address (0x28–0x3F, 0x68–0x7F) stores the address, but data writes to it are discarded. The next increment from 0x28–0x3F goes to 0x40; from 0x68–0x7F it goes to 0x00.
- Writes (RW=0), committed on E fall using values synchronized at that edge:
  - RS=1: DDRAM[addr]<=d, then addr +/-1 per inc_mode. Enter BUSY with BUSY_CYCLES.
  - RS=0, decoded by highest set bit:
    - 0x01 Clear: addr=0, inc_mode=1, go to CLEARING.
    - 0x02/0x03 Home: addr=0.
    - 0x04–0x07 Entry: inc_mode=d[1]; S ignored.
    - 0x08–0x0F: display_on=d[2].
    - 0x10–0x1F Shift: when d[3]=0, addr +/-1 with d[2] as direction.
    - 0x20–0x3F Function set: no effect.
    - 0x40–0x7F CGRAM: no effect.
    - 0x80–0xFF: addr=d[6:0].
  - Every command except Clear then enters BUSY with BUSY_CYCLES. Writing 0x00 is a no-op and does not set busy.
- Reads (RW=1):
  - On synchronized E rise, latch lcd_d_out. RS=0 returns {busy, addr}. RS=1 returns DDRAM[addr], or 0x20 if addr is unmapped.
  - lcd_d_oe = sync_E & sync_RW. Read data is valid 3 clk after lcd_e rises.
  - On E fall of an RS=1 read: addr +/-1, enter BUSY with BUSY_CYCLES.
- Rejection:
  - Any write, or any RS=1 read, whose E fall occurs while not in IDLE is ignored and pulses cmd_error for one cycle.
  - A busy-flag read (RS=0, RW=1) is always allowed.
- Simultaneous events: an E fall in the same cycle as the BUSY→IDLE transition is rejected (busy was still 1 when sampled).
- Reset mid-operation: a clear fill or busy count is aborted and restarts from CLEARING.
- mon_data: registered read of DDRAM[mon_addr] each cycle. Unmapped addresses return 0x20.

Decomposition:
- Package lcd_pkg:
  - Command mask constants (CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGRAM, DDRAM).
  - LINE1_END=0x27, LINE2_BASE=0x40, LINE2_END=0x67, BLANK=0x20.
  - FSM state type {CLEARING, BUSY, IDLE}.
  - Address increment/decrement functions.
- Sub-module hd44780_ddram: 80x8 storage with 7-bit→linear address translation. One write port, two registered read ports (host and monitor). Unmapped addresses read as 0x20 and ignore writes.

Test Plan:
- Reset release → busy=1 for CLEARING_CYCLES; then busy=0. Busy-flag read returns 0x00; mon_data at 0x00, 0x27, 0x40 and 0x67 all read 0x20.
- Write cmd 0x80|0x26, then data 'A', 'B', 'C' (each after busy clears) → DDRAM[0x26]=0x41, DDRAM[0x27]=0x42, DDRAM[0x40]=0x43. Busy-flag read returns 0x41.
- Entry 0x04 (decrement), set addr 0x00, write 'Z' → DDRAM[0x00]=0x5A; busy-flag read returns 0x67.
- Data write issued 10 clk after a previous write (busy=1) → cmd_error pulses once, DDRAM and addr unchanged. Busy-flag read during busy returns bit7=1.
- Set addr 0x40, write 'Q', set addr 0x40, RS=1 read → lcd_d_out=0x51 with lcd_d_oe=1 while E high. After E fall, addr=0x41.
- Write 0x0C → display_on=1. Write 0x01 → busy for CLEAR_CYCLES, all mon_data=0x20, addr=0. Assert reset mid-fill → outputs return to reset values and the fill restarts.
